// File: rtl/fp_pkg.sv
// Shared types for the parametrised floating-point add/subtract coprocessor.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADD,
    NORM,
    ROUND
  } state_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  typedef enum logic [2:0] {
    ZERO,
    NORMAL,
    INF,
    QNAN,
    SNAN
  } fp_class_t;

  // Operand class from width-independent field summaries; subnormals read as zero.
  function automatic fp_class_t classify(input logic exp_zero, input logic exp_ones,
                                         input logic frac_zero, input logic frac_msb);
    if (exp_zero) return ZERO;
    if (!exp_ones) return NORMAL;
    if (frac_zero) return INF;
    return frac_msb ? QNAN : SNAN;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter with an all-zero indicator.
module fp_lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W)
) (
  input  logic [W-1:0]  in_v,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  logic found;

  // Priority scan from the MSB; cnt is 0 when the input is all zero.
  always_comb begin
    cnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found && in_v[W-1-i]) begin
        cnt   = CW'(i);
        found = 1'b1;
      end
    end
    zero = ~|in_v;
  end

endmodule

// File: rtl/fp_addsub_param.sv
// Multi-cycle IEEE-754 adder/subtractor with RNE rounding and exception flags.
module fp_addsub_param
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   oper,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic [EXP_W+MAN_W:0]   R,
  output logic                   ready,
  output logic                   busy,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;   // hidden + fraction + guard/round/sticky
  localparam int AW = MAN_W + 5;   // adder width with carry-out
  localparam int EW = EXP_W + 2;   // signed exponent with headroom both ways
  localparam int CW = $clog2(SW);

  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [EW-1:0] EMAX     = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO    = '0;
  localparam logic [EW-1:0]        DMAX     = EW'(SW - 1);
  localparam logic [W-1:0]         QNAN_W   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_t                 state_q, state_d;
  logic [W-1:0]           a_q, a_d, b_q, b_d, r_q, r_d;
  logic                   oper_q, oper_d;
  flags_t                 flags_q, flags_d;
  logic                   ready_q, ready_d, busy_q, busy_d;
  logic                   sign_q, sign_d, sub_q, sub_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [SW-1:0]          sig_l_q, sig_l_d, sig_s_q, sig_s_d, norm_q, norm_d;
  logic [AW-1:0]          sum_q, sum_d;

  logic [EXP_W-1:0]       a_exp, b_exp, exp_big, exp_small;
  logic [MAN_W-1:0]       a_frac, b_frac, frac_big, frac_small;
  logic                   a_sign, eff_sb, a_big;
  fp_class_t              cls_a, cls_b;
  logic [EW-1:0]          d_raw, d_sat;
  logic [SW-1:0]          sig_small, mask, aligned;
  logic [CW-1:0]          lz_cnt;
  logic                   lz_zero;
  logic                   g_bit, r_bit, s_bit, inc;
  logic [MAN_W:0]         frac_r;
  logic signed [EW-1:0]   exp_r;

  assign a_sign = a_q[W-1];
  assign a_exp  = a_q[W-2:MAN_W];
  assign a_frac = a_q[MAN_W-1:0];
  assign b_exp  = b_q[W-2:MAN_W];
  assign b_frac = b_q[MAN_W-1:0];
  assign eff_sb = b_q[W-1] ^ oper_q;
  assign cls_a  = classify(a_exp == '0, a_exp == EXP_ONES, a_frac == '0, a_frac[MAN_W-1]);
  assign cls_b  = classify(b_exp == '0, b_exp == EXP_ONES, b_frac == '0, b_frac[MAN_W-1]);

  fp_lzc #(.W(SW), .CW(CW)) u_lzc (
    .in_v (sum_q[SW-1:0]),
    .cnt  (lz_cnt),
    .zero (lz_zero)
  );

  // Alignment and rounding arithmetic, consumed by the FSM in ALIGN and ROUND.
  always_comb begin
    a_big      = a_q[W-2:0] >= b_q[W-2:0];
    exp_big    = a_big ? a_exp  : b_exp;
    exp_small  = a_big ? b_exp  : a_exp;
    frac_big   = a_big ? a_frac : b_frac;
    frac_small = a_big ? b_frac : a_frac;
    d_raw      = {2'b00, exp_big} - {2'b00, exp_small};
    d_sat      = (d_raw > DMAX) ? DMAX : d_raw;
    sig_small  = {1'b1, frac_small, 3'b000};
    mask       = ~({SW{1'b1}} << d_sat);
    aligned    = (sig_small >> d_sat) | {{(SW-1){1'b0}}, |(sig_small & mask)};

    g_bit  = norm_q[2];
    r_bit  = norm_q[1];
    s_bit  = norm_q[0];
    inc    = g_bit & (r_bit | s_bit | norm_q[3]);
    frac_r = {1'b0, norm_q[SW-2:3]} + {{MAN_W{1'b0}}, inc};
    exp_r  = exp_q + $signed({{(EW-1){1'b0}}, frac_r[MAN_W]});
  end

  // Next-state and datapath register updates for each FSM phase.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    oper_d  = oper_q;
    r_d     = r_q;
    flags_d = flags_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    sig_l_d = sig_l_q;
    sig_s_d = sig_s_q;
    sum_d   = sum_q;
    norm_d  = norm_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          oper_d  = oper;
          busy_d  = 1'b1;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        flags_d = '0;
        if (cls_a == QNAN || cls_a == SNAN || cls_b == QNAN || cls_b == SNAN) begin
          r_d             = QNAN_W;
          flags_d.invalid = (cls_a == SNAN) || (cls_b == SNAN);
        end else if (cls_a == INF && cls_b == INF) begin
          if (a_sign != eff_sb) begin
            r_d             = QNAN_W;
            flags_d.invalid = 1'b1;
          end else begin
            r_d = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
          end
        end else if (cls_a == INF) begin
          r_d = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (cls_b == INF) begin
          r_d = {eff_sb, EXP_ONES, {MAN_W{1'b0}}};
        end else if (cls_a == ZERO && cls_b == ZERO) begin
          r_d = {a_sign & eff_sb, {(W-1){1'b0}}};
        end else if (cls_a == ZERO) begin
          r_d = {eff_sb, b_q[W-2:0]};
        end else if (cls_b == ZERO) begin
          r_d = {a_sign, a_q[W-2:0]};
        end else begin
          // Both normal: undo the early completion and continue the pipeline.
          ready_d = 1'b0;
          busy_d  = 1'b1;
          r_d     = r_q;
          flags_d = flags_q;
          state_d = ALIGN;
        end
      end

      ALIGN: begin
        sign_d  = a_big ? a_sign : eff_sb;
        sub_d   = a_sign ^ eff_sb;
        exp_d   = $signed({2'b00, exp_big});
        sig_l_d = {1'b1, frac_big, 3'b000};
        sig_s_d = aligned;
        state_d = ADD;
      end

      ADD: begin
        sum_d   = sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                        : ({1'b0, sig_l_q} + {1'b0, sig_s_q});
        state_d = NORM;
      end

      NORM: begin
        if (sum_q[AW-1]) begin
          norm_d = {sum_q[AW-1:2], sum_q[1] | sum_q[0]};
          exp_d  = exp_q + $signed({{(EW-1){1'b0}}, 1'b1});
        end else if (lz_zero) begin
          norm_d = '0;
        end else begin
          norm_d = sum_q[SW-1:0] << lz_cnt;
          exp_d  = exp_q - $signed({{(EW-CW){1'b0}}, lz_cnt});
        end
        state_d = ROUND;
      end

      ROUND: begin
        flags_d = '0;
        // A cleared hidden bit only happens for an exact-zero sum.
        if (!norm_q[SW-1]) begin
          r_d = '0;
        end else if (exp_r >= EMAX) begin
          r_d              = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
          flags_d.overflow = 1'b1;
          flags_d.inexact  = 1'b1;
        end else if (exp_r <= EZERO) begin
          r_d               = {sign_q, {(W-1){1'b0}}};
          flags_d.underflow = 1'b1;
          flags_d.inexact   = 1'b1;
        end else begin
          r_d             = {sign_q, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
          flags_d.inexact = g_bit | r_bit | s_bit;
        end
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      oper_q  <= 1'b0;
      r_q     <= '0;
      flags_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      sig_l_q <= '0;
      sig_s_q <= '0;
      sum_q   <= '0;
      norm_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      oper_q  <= oper_d;
      r_q     <= r_d;
      flags_q <= flags_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      sig_l_q <= sig_l_d;
      sig_s_q <= sig_s_d;
      sum_q   <= sum_d;
      norm_q  <= norm_d;
    end
  end

  assign R     = r_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_fp_addsub_param.sv
// Self-checking bench: single- and half-precision instances, table vectors with a
// result scoreboard, plus hand sequences for ignored start and mid-operation reset.
module tb_fp_addsub_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start32 = 1'b0, oper32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, r32;
  logic        ready32, busy32;
  logic [3:0]  flags32;
  logic        start16 = 1'b0, oper16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, r16;
  logic        ready16, busy16;
  logic [3:0]  flags16;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_addsub_param u_sp (
    .clk(clk), .reset(reset), .start(start32), .oper(oper32), .A(a32), .B(b32),
    .R(r32), .ready(ready32), .busy(busy32), .flags(flags32)
  );

  fp_addsub_param #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clk(clk), .reset(reset), .start(start16), .oper(oper16), .A(a16), .B(b16),
    .R(r16), .ready(ready16), .busy(busy16), .flags(flags16)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    int          t0;
    int          idx;
  } exp_t;

  exp_t sb32[$];
  exp_t sb16[$];
  vec_t tv[20];
  vec_t hv[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!reset && ready32 === 1'b1) begin
      if (sb32.size() == 0) begin
        check("stray_ready_sp", 32'(ready32), 32'd0);
      end else begin
        e = sb32.pop_front();
        check($sformatf("sp%0d_R", e.idx), r32, e.r);
        check($sformatf("sp%0d_flags", e.idx), 32'(flags32), 32'(e.f));
        check($sformatf("sp%0d_latency", e.idx), cyc - e.t0, e.lat);
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (!reset && ready16 === 1'b1) begin
      if (sb16.size() == 0) begin
        check("stray_ready_hp", 32'(ready16), 32'd0);
      end else begin
        e = sb16.pop_front();
        check($sformatf("hp%0d_R", e.idx), {16'h0, r16}, e.r);
        check($sformatf("hp%0d_flags", e.idx), 32'(flags16), 32'(e.f));
        check($sformatf("hp%0d_latency", e.idx), cyc - e.t0, e.lat);
      end
    end
  end

  // Drive one operation from a negedge; expected result is queued once start is taken.
  task automatic issue(input bit half, input vec_t v, input int idx);
    exp_t e;
    if (half) begin
      a16 = v.a[15:0]; b16 = v.b[15:0]; oper16 = v.op; start16 = 1'b1;
    end else begin
      a32 = v.a; b32 = v.b; oper32 = v.op; start32 = 1'b1;
    end
    @(negedge clk);
    start16 = 1'b0;
    start32 = 1'b0;
    e.r = v.r; e.f = v.f; e.lat = v.lat; e.t0 = cyc; e.idx = idx;
    if (half) begin
      sb16.push_back(e);
      check($sformatf("hp%0d_busy", idx), 32'(busy16), 32'd1);
    end else begin
      sb32.push_back(e);
      check($sformatf("sp%0d_busy", idx), 32'(busy32), 32'd1);
    end
  endtask

  task automatic drain(input bit half);
    int n;
    int sz;
    n = 0;
    sz = half ? sb16.size() : sb32.size();
    while (sz != 0 && n < 40) begin
      @(negedge clk);
      n++;
      sz = half ? sb16.size() : sb32.size();
    end
    if (sz != 0) begin
      check(half ? "timeout_hp" : "timeout_sp", sz, 0);
      if (half) sb16.delete(); else sb32.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{32'h41C00000, 32'h40000000, 1'b1, 32'h41B00000, 4'h0, 5};
    tv[1]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1, 5};
    tv[2]  = '{32'h40800000, 32'h40800000, 1'b1, 32'h00000000, 4'h0, 5};
    tv[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5, 5};
    tv[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8, 1};
    tv[5]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8, 1};
    tv[6]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0, 5};
    tv[7]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0, 5};
    tv[8]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1, 5};
    tv[9]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0, 1};
    tv[10] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'h0, 1};
    tv[11] = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'h0, 1};
    tv[12] = '{32'h00000001, 32'h40000000, 1'b0, 32'h40000000, 4'h0, 1};
    tv[13] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0, 1};
    tv[14] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0, 1};
    tv[15] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h3, 5};
    tv[16] = '{32'h7F000000, 32'h3F800000, 1'b0, 32'h7F000000, 4'h1, 5};
    tv[17] = '{32'h3F800000, 32'h33000000, 1'b1, 32'h3F800000, 4'h1, 5};
    tv[18] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'h0, 5};
    tv[19] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0, 1};

    hv[0] = '{32'h3C00, 32'h3C00, 1'b0, 32'h4000, 4'h0, 5};
    hv[1] = '{32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'h5, 5};
    hv[2] = '{32'h3C00, 32'h3C00, 1'b1, 32'h0000, 4'h0, 5};
    hv[3] = '{32'h7C00, 32'h7C00, 1'b1, 32'h7E00, 4'h8, 1};
    hv[4] = '{32'h3C00, 32'h1000, 1'b0, 32'h3C00, 4'h1, 5};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_R_sp", r32, 32'h0);
    check("reset_ready_sp", 32'(ready32), 32'd0);
    check("reset_busy_sp", 32'(busy32), 32'd0);
    check("reset_flags_sp", 32'(flags32), 32'd0);
    check("reset_R_hp", {16'h0, r16}, 32'h0);

    // Back-to-back issue: each new start lands in the cycle the previous ready is seen.
    for (int i = 0; i < 20; i++) begin
      issue(1'b0, tv[i], i);
      drain(1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, hv[i], i);
      drain(1'b1);
    end

    // Ready is a single pulse and R/flags hold afterwards.
    issue(1'b0, tv[3], 100);
    drain(1'b0);
    repeat (2) @(negedge clk);
    check("hold_ready_sp", 32'(ready32), 32'd0);
    check("hold_R_sp", r32, 32'h7F800000);
    check("hold_flags_sp", 32'(flags32), 32'h5);

    // A start pulse while busy must be ignored entirely.
    issue(1'b0, tv[0], 101);
    @(negedge clk);
    a32 = 32'h3F800000; b32 = 32'h3F800000; oper32 = 1'b0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    drain(1'b0);
    repeat (10) @(negedge clk);
    check("ignored_start_busy", 32'(busy32), 32'd0);
    check("ignored_start_R", r32, 32'h41B00000);

    // Reset in the middle of an operation clears everything, no stale ready later.
    a32 = 32'h3F800000; b32 = 32'h40000000; oper32 = 1'b0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    @(negedge clk);
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midop_reset_R", r32, 32'h0);
    check("midop_reset_ready", 32'(ready32), 32'd0);
    check("midop_reset_busy", 32'(busy32), 32'd0);
    check("midop_reset_flags", 32'(flags32), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_busy", 32'(busy32), 32'd0);

    // Recovery after reset.
    issue(1'b0, tv[1], 102);
    drain(1'b0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
